// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// operand width, op codes (shared with controlunit decode), FSM states, decode helpers.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    typedef struct packed {
        logic is_div;
        logic sgn_a;
        logic sgn_b;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t info;
        info.is_div = (op >= OP_DIV);
        info.sgn_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        info.sgn_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        return info;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

    // Operations whose result is fixed without iterating.
    function automatic logic is_trivial(input logic [4:0] op, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        op_info_t info;
        info = decode_op(op);
        if (info.is_div)
            return (b == '0) || (info.sgn_a && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step sharing a single adder: shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   opa;
    logic [XLEN+1:0] opb;
    logic [XLEN+1:0] sum;

    always_comb begin
        if (i_is_div) begin
            opa = {i_hi, i_lo[XLEN-1]};
            opb = ~{2'b00, i_b};
        end else begin
            opa = {1'b0, i_hi};
            opb = i_lo[0] ? {2'b00, i_b} : '0;
        end
        // Divide subtracts via inverted operand plus carry-in; bit XLEN+1 flags a borrow.
        sum = {1'b0, opa} + opb + {{(XLEN+1){1'b0}}, i_is_div};

        if (!i_is_div) begin
            o_hi = sum[XLEN:1];
            o_lo = {sum[0], i_lo[XLEN-1:1]};
        end else if (!sum[XLEN+1]) begin
            o_hi = sum[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b1};
        end else begin
            o_hi = opa[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32 radix-2 steps on magnitudes, sign fix at DONE.
// Optional MULDIV_EARLY_OUT_EN skips CALC for div-by-zero, signed overflow and zero-operand multiply.
module muldiv_seq #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [4:0]      i_alu_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);
    import muldiv_pkg::*;

    state_e          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    op_info_t          cur, inc;
    logic              launch;
    logic [XLEN-1:0]   step_b, step_hi, step_lo;
    logic              div0, ovf, mulz, neg_res, neg_rem;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot, rem, done_res;

    assign cur    = decode_op(op_q);
    assign inc    = decode_op(i_alu_op);
    assign launch = (state_q == IDLE) && i_start && !i_flush
                    && (i_alu_op >= OP_MUL) && (i_alu_op <= OP_REMU);
    assign step_b = cur.is_div ? mag(rs2_q, cur.sgn_b) : mag(rs1_q, cur.sgn_a);

    muldiv_step u_step (
        .i_is_div (cur.is_div),
        .i_hi     (hi_q),
        .i_lo     (lo_q),
        .i_b      (step_b),
        .o_hi     (step_hi),
        .o_lo     (step_lo)
    );

    // Fixed-result cases are overridden here so both builds return identical values.
    always_comb begin
        div0    = cur.is_div && (rs2_q == '0);
        ovf     = cur.is_div && cur.sgn_a && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);
        mulz    = !cur.is_div && ((rs1_q == '0) || (rs2_q == '0));
        neg_res = (cur.sgn_a && rs1_q[XLEN-1]) ^ (cur.sgn_b && rs2_q[XLEN-1]);
        neg_rem = cur.sgn_a && rs1_q[XLEN-1];
        prod    = {hi_q, lo_q};
        prod_s  = neg_res ? (~prod + 1'b1) : prod;
        quot    = neg_res ? (~lo_q + 1'b1) : lo_q;
        rem     = neg_rem ? (~hi_q + 1'b1) : hi_q;
        done_res = '0;
        case (op_q)
            OP_MUL:                       done_res = mulz ? '0 : prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: done_res = mulz ? '0 : prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              done_res = div0 ? '1 : ovf ? {1'b1, {(XLEN-1){1'b0}}} : quot;
            OP_REM, OP_REMU:              done_res = div0 ? rs1_q : ovf ? '0 : rem;
            default:                      done_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        valid_d  = 1'b0;
        result_d = '0;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (launch) begin
                    op_d    = i_alu_op;
                    rs1_d   = i_rs1;
                    rs2_d   = i_rs2;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = inc.is_div ? mag(i_rs1, inc.sgn_a) : mag(i_rs2, inc.sgn_b);
                    state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (is_trivial(i_alu_op, i_rs1, i_rs2))
                        state_d = DONE;
`endif
                end
                CALC: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_d = DONE;
                end
                DONE: begin
                    valid_d  = 1'b1;
                    result_d = done_res;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_stall  = i_reset && ((state_q == CALC) || launch);
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule
